// File: rtl/writeback_stage.sv
// Final pipeline stage: picks the writeback source, runs the load handshake with
// data memory and drives the register file write port. Optional macro: WB_MISALIGN_CHK_EN.
module writeback_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_o,
    input  logic            rst,
    input  logic            valid_i,
    input  logic            flush_i,
    output logic            stall_o,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    input  logic [RA_W-1:0] rd_i,
    input  logic            reg_wr_i,
    input  logic [1:0]      wb_sel_i,
    input  logic [2:0]      funct3_i,
    output logic            dmem_req_o,
    output logic [XLEN-1:0] dmem_addr_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
`ifdef WB_MISALIGN_CHK_EN
    output logic            misalign_o,
`endif
    output logic [RA_W-1:0] waddr_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            reg_wr_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMMIT    = 2'd1,
        LOAD_WAIT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [RA_W-1:0] waddr_reg, waddr_next;
    logic [XLEN-1:0] wdata_reg, wdata_next;
    logic            reg_wr_reg, reg_wr_next;
    logic            req_reg, req_next;
    logic [XLEN-1:0] addr_reg, addr_next;
    logic [2:0]      funct3_reg, funct3_next;
    logic            load_wr_reg, load_wr_next;
`ifdef WB_MISALIGN_CHK_EN
    logic            misalign_reg, misalign_next;
    logic            misaligned;
`endif

    logic            accept;
    logic            write_ok;
    logic [XLEN-1:0] nonload_data;
    logic [XLEN-1:0] load_data;
    logic [1:0]      a;
    logic [7:0]      byte_lane [4];
    logic [15:0]     half_lane [2];
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    // Little-endian lane split of the returned word
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = dmem_rdata_i[8*gi +: 8];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_half_lane
            assign half_lane[gi] = dmem_rdata_i[16*gi +: 16];
        end
    endgenerate

    // Without the alignment check, halves ignore a[0] and words ignore a entirely
    assign a        = addr_reg[1:0];
    assign byte_sel = byte_lane[a];
    assign half_sel = half_lane[a[1]];

    always_comb begin
        load_data = dmem_rdata_i;
        case (funct3_reg)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        nonload_data = alu_res_i;
        if (wb_sel_i == 2'b10) begin
            nonload_data = pc_plus4_i;
        end
    end

`ifdef WB_MISALIGN_CHK_EN
    always_comb begin
        misaligned = 1'b0;
        case (funct3_i)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = alu_res_i[0];
            default:        misaligned = (alu_res_i[1:0] != 2'b00);
        endcase
    end
`endif

    assign accept   = (state_reg != LOAD_WAIT) && valid_i && !flush_i;
    assign write_ok = reg_wr_i && (rd_i != '0);

    always_comb begin
        state_next   = state_reg;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;
        reg_wr_next  = 1'b0;
        req_next     = req_reg;
        addr_next    = addr_reg;
        funct3_next  = funct3_reg;
        load_wr_next = load_wr_reg;
`ifdef WB_MISALIGN_CHK_EN
        misalign_next = 1'b0;
`endif
        case (state_reg)
            IDLE, COMMIT: begin
                state_next = IDLE;
                if (accept) begin
                    waddr_next = rd_i;
                    if (wb_sel_i == 2'b01) begin
                        addr_next    = alu_res_i;
                        funct3_next  = funct3_i;
                        load_wr_next = write_ok;
`ifdef WB_MISALIGN_CHK_EN
                        if (misaligned) begin
                            state_next    = COMMIT;
                            misalign_next = 1'b1;
                        end else begin
                            state_next = LOAD_WAIT;
                            req_next   = 1'b1;
                        end
`else
                        state_next = LOAD_WAIT;
                        req_next   = 1'b1;
`endif
                    end else begin
                        state_next  = COMMIT;
                        reg_wr_next = write_ok;
                        if (write_ok) begin
                            wdata_next = nonload_data;
                        end
                    end
                end
            end
            LOAD_WAIT: begin
                // Upstream valid/flush are ignored here; only the ack ends the wait
                if (dmem_ack_i) begin
                    state_next  = COMMIT;
                    req_next    = 1'b0;
                    reg_wr_next = load_wr_reg;
                    if (load_wr_reg) begin
                        wdata_next = load_data;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_o or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            reg_wr_reg   <= 1'b0;
            req_reg      <= 1'b0;
            addr_reg     <= '0;
            funct3_reg   <= '0;
            load_wr_reg  <= 1'b0;
`ifdef WB_MISALIGN_CHK_EN
            misalign_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
            reg_wr_reg   <= reg_wr_next;
            req_reg      <= req_next;
            addr_reg     <= addr_next;
            funct3_reg   <= funct3_next;
            load_wr_reg  <= load_wr_next;
`ifdef WB_MISALIGN_CHK_EN
            misalign_reg <= misalign_next;
`endif
        end
    end

    assign stall_o     = (state_reg == LOAD_WAIT);
    assign dmem_req_o  = req_reg;
    assign dmem_addr_o = addr_reg;
    assign waddr_o     = waddr_reg;
    assign wdata_o     = wdata_reg;
    assign reg_wr_o    = reg_wr_reg;
`ifdef WB_MISALIGN_CHK_EN
    assign misalign_o  = misalign_reg;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (third) pipeline stage; consumes execute-stage results and drives the register file write port (waddr, wdata, reg_wr_E).
- Selects the writeback source: ALU result, load data or PC+4.
- Runs the load handshake with data memory and applies RV32I byte/half/word extraction with sign or zero extension.
- Stalls upstream while a load is outstanding.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width

Ports:
- clk_o  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  execute stage presents a valid instruction
- flush_i  in  1  discard the instruction presented this cycle
- stall_o  out  1  upstream must hold its outputs
- alu_res_i  in  XLEN  ALU result; also the load address
- pc_plus4_i  in  XLEN  PC+4 for jal/jalr
- rd_i  in  RA_W  destination register
- reg_wr_i  in  1  instruction writes rd
- wb_sel_i  in  2  source select: 00 ALU, 01 MEM, 10 PC+4, 11 ALU
- funct3_i  in  3  load width/sign
- dmem_req_o  out  1  load request to data memory
- dmem_addr_o  out  XLEN  byte address of the load
- dmem_ack_i  in  1  load data valid this cycle
- dmem_rdata_i  in  XLEN  aligned word from memory
- waddr_o  out  RA_W  to register file waddr
- wdata_o  out  XLEN  to register file wdata
- reg_wr_o  out  1  to register file reg_wr_E

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0.
- All outputs are registered on posedge clk_o. They are stable across the register file's negedge write.
- States:
  - IDLE: no commit pending.
  - COMMIT: reg_wr_o asserted for exactly one cycle.
  - LOAD_WAIT: a load is outstanding.
- Acceptance in IDLE or COMMIT: when valid_i=1 and flush_i=0, fields are captured at the posedge.
  - wb_sel_i=01 goes to LOAD_WAIT.
  - Any other wb_sel_i goes to COMMIT.
  - No acceptance returns to IDLE.
  - Back-to-back non-loads commit one per cycle.
- Non-load latency: accepted at posedge N; waddr_o/wdata_o/reg_wr_o valid during cycle N to N+1.
- Non-load wdata_o: alu_res_i for 00/11, pc_plus4_i for 10.
- LOAD_WAIT:
  - dmem_req_o=1 and dmem_addr_o=captured alu_res, held constant until ack.
  - stall_o=1 (combinational from state).
  - valid_i and flush_i are ignored; a load that reached this stage is never cancelled.
  - On the posedge where dmem_ack_i=1: dmem_req_o drops, extracted data goes to wdata_o, state goes to COMMIT. Write is one cycle after ack.
  - No timeout; ack may take any number of cycles. An ack outside LOAD_WAIT is ignored.
- Load extraction is little-endian; a = captured address[1:0]:
  - 000 lb: byte a, sign-extended
  - 001 lh: half a[1], sign-extended
  - 010 lw: full word
  - 100 lbu: byte a, zero-extended
  - 101 lhu: half a[1], zero-extended
  - Other funct3 values: treated as lw.
- reg_wr_o = captured reg_wr_i AND rd!=0. A write to x0 is never issued.
- waddr_o always equals the captured rd. wdata_o holds its value when reg_wr_o=0.
- stall_o=0 in IDLE and COMMIT.
- Reset during LOAD_WAIT: the load is dropped, dmem_req_o=0, and no write is issued.

Optional Feature:
- Macro: WB_MISALIGN_CHK_EN.
- Defined:
  - Adds output misalign_o (1 bit).
  - An accepted load goes straight to COMMIT when lh/lhu has a[0]=1, or lw has a!=0.
  - For such a load: reg_wr_o=0, misalign_o=1 for one cycle, dmem_req_o never asserted.
- Undefined:
  - Port absent.
  - Address low bits are masked to natural alignment (lh/lhu ignore a[0]; lw ignores a) and the load proceeds normally.

Test Plan:
- ALU op, rd=5, alu_res=0x0000_1234, wb_sel=00 -> next cycle waddr=5, wdata=0x1234, reg_wr=1 for exactly 1 cycle.
- jal: rd=1, pc_plus4=0x0000_0104, wb_sel=10 -> wdata=0x104, reg_wr=1; then rd=0 with reg_wr_i=1 -> reg_wr_o=0.
- lb, addr=0x...03, dmem_rdata=0x80FF_1234, ack after 3 cycles -> stall_o=1 for 3 cycles, addr held, then wdata=0xFFFF_FF80. lbu at the same address -> 0x0000_0080.
- lh at addr 0x2 with rdata=0x8001_0000 -> 0xFFFF_8001; lhu -> 0x0000_8001; lw -> 0x8001_0000.
- 3 back-to-back ALU ops (rd 2,3,4) -> 3 consecutive commit cycles, stall_o=0. flush_i=1 on the 2nd -> only rd 2 and 4 written.
- Assert rst mid-LOAD_WAIT -> dmem_req_o, reg_wr_o, stall_o all 0 immediately. A later ack -> no write.
